// File: rtl/seven_seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl_if
//  Brief    : Bundles the numeric-datapath side (enable, load, BCD word,
//             decimal points) and the board-pin side (anodes, segments,
//             decimal point, frame pulse) of the 7-segment scan controller.
//  Revision : 1.0  initial release
// ============================================================================
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      enable;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   bcd_in;
   logic [NUM_DIGITS-1:0]     dp_in;
   logic [NUM_DIGITS-1:0]     an_n;
   logic [6:0]                seg_n;
   logic                      dp_n;
   logic                      frame_done;

   // Driver side: the datapath that supplies digits and watches the scan.
   modport master (
      output enable, load, bcd_in, dp_in,
      input  an_n, seg_n, dp_n, frame_done
   );

   // Controller side.
   modport slave (
      input  enable, load, bcd_in, dp_in,
      output an_n, seg_n, dp_n, frame_done
   );
endinterface : seven_seg_scan_ctrl_if
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scan_ctrl (+ bcd_to_7seg decoder)
//  Brief    : Time-multiplexed scan controller for a common-anode 7-segment
//             display. Tear-free double-buffered BCD capture, blanking guard
//             at the start of every digit slot, one-cycle frame_done pulse.
//  Option   : define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
//  Revision : 1.0  initial release
// ============================================================================

// 4-bit BCD to active-low segments {g..a}; codes 10-15 blank the digit.
module bcd_to_7seg (
   input  wire logic [3:0] bcd,
   output logic      [6:0] seg_n
);
   // Pure lookup of the common-anode segment pattern.
   always_comb begin
      case (bcd)
         4'd0:    seg_n = 7'b1000000;
         4'd1:    seg_n = 7'b1111001;
         4'd2:    seg_n = 7'b0100100;
         4'd3:    seg_n = 7'b0110000;
         4'd4:    seg_n = 7'b0011001;
         4'd5:    seg_n = 7'b0010010;
         4'd6:    seg_n = 7'b0000010;
         4'd7:    seg_n = 7'b1111000;
         4'd8:    seg_n = 7'b0000000;
         4'd9:    seg_n = 7'b0010000;
         default: seg_n = 7'b1111111;
      endcase
   end
endmodule : bcd_to_7seg

module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   seven_seg_scan_ctrl_if.slave  bus
);
   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int BCD_W = 4 * NUM_DIGITS;

   localparam logic [DIV_W-1:0] c_blank_last = DIV_W'(BLANK_CYCLES - 1);
   localparam logic [DIV_W-1:0] c_slot_last  = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] c_last_digit = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t                 state_q,       state_d;
   logic [IDX_W-1:0]       digit_idx_q,   digit_idx_d;
   logic [DIV_W-1:0]       div_cnt_q,     div_cnt_d;
   logic [BCD_W-1:0]       shadow_q,      shadow_d;
   logic [NUM_DIGITS-1:0]  shadow_dp_q,   shadow_dp_d;
   logic [BCD_W-1:0]       staging_q,     staging_d;
   logic [NUM_DIGITS-1:0]  staging_dp_q,  staging_dp_d;
   logic                   pending_q,     pending_d;
   logic [NUM_DIGITS-1:0]  an_n_q,        an_n_d;
   logic [6:0]             seg_n_q,       seg_n_d;
   logic                   dp_n_q,        dp_n_d;
   logic                   frame_done_q,  frame_done_d;

   logic [3:0]             dec_bcd;
   logic [6:0]             dec_seg;
   logic                   suppress;

   // Shadow only changes on edges that lead into BLANK or IDLE, so the
   // registered shadow is always the right source for the next SHOW cycle.
   assign dec_bcd = shadow_q[{digit_idx_d, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .bcd   (dec_bcd),
      .seg_n (dec_seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_blank;

   // A digit above 0 is a leading zero when it and every higher digit are
   // zero with no decimal point lit.
   always_comb begin
      logic run_zero;
      run_zero = 1'b1;
      lz_blank = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         run_zero    = run_zero && (shadow_q[4*k +: 4] == 4'd0) && !shadow_dp_q[k];
         lz_blank[k] = (k != 0) && run_zero;
      end
   end

   assign suppress = lz_blank[digit_idx_d];
`else
   assign suppress = 1'b0;
`endif

   // Next-state: scan sequencing, double-buffer commit and registered outputs.
   always_comb begin
      state_d      = state_q;
      digit_idx_d  = digit_idx_q;
      div_cnt_d    = div_cnt_q;
      shadow_d     = shadow_q;
      shadow_dp_d  = shadow_dp_q;
      staging_d    = staging_q;
      staging_dp_d = staging_dp_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;

      if (state_q == ST_IDLE) begin
         if (bus.load) begin
            shadow_d    = bus.bcd_in;
            shadow_dp_d = bus.dp_in;
         end
         if (bus.enable) begin
            state_d     = ST_BLANK;
            digit_idx_d = '0;
            div_cnt_d   = '0;
         end
      end else if (!bus.enable) begin
         // Leaving the scan: whatever the datapath last supplied takes effect.
         state_d     = ST_IDLE;
         digit_idx_d = '0;
         div_cnt_d   = '0;
         pending_d   = 1'b0;
         if (bus.load) begin
            shadow_d    = bus.bcd_in;
            shadow_dp_d = bus.dp_in;
         end else if (pending_q) begin
            shadow_d    = staging_q;
            shadow_dp_d = staging_dp_q;
         end
      end else begin
         if (state_q == ST_BLANK) begin
            div_cnt_d = div_cnt_q + 1'b1;
            if (div_cnt_q == c_blank_last) begin
               state_d = ST_SHOW;
            end
         end else if (div_cnt_q == c_slot_last) begin
            state_d   = ST_BLANK;
            div_cnt_d = '0;
            if (digit_idx_q == c_last_digit) begin
               digit_idx_d  = '0;
               frame_done_d = 1'b1;
               // Commit uses the staging value from before this edge, so a
               // coincident load waits for the following boundary.
               if (pending_q) begin
                  shadow_d    = staging_q;
                  shadow_dp_d = staging_dp_q;
                  pending_d   = 1'b0;
               end
            end else begin
               digit_idx_d = digit_idx_q + 1'b1;
            end
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end

         if (bus.load) begin
            staging_d    = bus.bcd_in;
            staging_dp_d = bus.dp_in;
            pending_d    = 1'b1;
         end
      end

      an_n_d  = '1;
      seg_n_d = 7'h7F;
      dp_n_d  = 1'b1;
      if (state_d == ST_SHOW) begin
         an_n_d = ~(NUM_DIGITS'(1) << digit_idx_d);
         if (!suppress) begin
            seg_n_d = dec_seg;
            dp_n_d  = ~shadow_dp_q[digit_idx_d];
         end
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         digit_idx_q  <= '0;
         div_cnt_q    <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         staging_q    <= '0;
         staging_dp_q <= '0;
         pending_q    <= 1'b0;
         an_n_q       <= '1;
         seg_n_q      <= 7'h7F;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         digit_idx_q  <= digit_idx_d;
         div_cnt_q    <= div_cnt_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         staging_q    <= staging_d;
         staging_dp_q <= staging_dp_d;
         pending_q    <= pending_d;
         an_n_q       <= an_n_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.an_n       = an_n_q;
   assign bus.seg_n      = seg_n_q;
   assign bus.dp_n       = dp_n_q;
   assign bus.frame_done = frame_done_q;

endmodule : seven_seg_scan_ctrl
`default_nettype wire

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NUM_DIGITS common-anode 7-segment display.
- Shares one instance of the team's 4-bit BCD to 7-segment decoder (bcd_to_7seg, active-low segment codes, blank for 10-15) across all digits.
- Latches a packed BCD word without tearing, cycles digit anodes with a blanking guard between slots, and flags frame completion.
- Sits between the system-level numeric datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; range 2..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= BLANK_CYCLES+1.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off (anti-ghosting); must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- enable  input  1  scan enable; low forces display dark
- load  input  1  one-cycle strobe: capture bcd_in and dp_in
- bcd_in  input  4*NUM_DIGITS  packed BCD; digit 0 (least significant) = bits [3:0]
- dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
- an_n  output  NUM_DIGITS  anode enables, active-low, at most one low
- seg_n  output  7  segments {g..a}, active-low, from bcd_to_7seg
- dp_n  output  1  decimal point, active-low
- frame_done  output  1  one-cycle pulse at end of each full scan

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n low at a clk edge) sets: an_n all 1, seg_n 7'h7F, dp_n 1, frame_done 0; state IDLE; digit_idx 0; div_cnt 0; shadow, staging and pending all 0.
- Reset has priority over every other input, including mid-slot and mid-load.
- All outputs are registered. an_n, seg_n and dp_n change on the same edge.
- FSM states are IDLE, BLANK and SHOW.
- IDLE:
  - Outputs stay dark.
  - load writes shadow directly.
  - When enable is 1, go to BLANK with digit_idx 0 and div_cnt 0.
- BLANK:
  - an_n all 1, seg_n 7'h7F, dp_n 1.
  - Lasts BLANK_CYCLES cycles, then go to SHOW.
- SHOW:
  - an_n[digit_idx] = 0.
  - seg_n = decoder(shadow nibble digit_idx).
  - dp_n = ~shadow_dp[digit_idx].
  - Lasts REFRESH_DIV-BLANK_CYCLES cycles.
  - Then go to BLANK with digit_idx+1, wrapping NUM_DIGITS-1 to 0.
- div_cnt counts 0..REFRESH_DIV-1 per slot and wraps at slot end. Slot period is exactly REFRESH_DIV cycles.
- Frame boundary is the edge where SHOW of digit NUM_DIGITS-1 ends.
  - frame_done = 1 for exactly the one cycle following that edge.
  - If pending = 1 at that edge, staging is copied to shadow and pending is cleared.
- Load outside IDLE:
  - load captures bcd_in and dp_in into staging and sets pending.
  - A later load before the boundary overwrites staging; last value wins.
  - A load coincident with the boundary edge is committed at the next boundary, not this one. The value in effect at this boundary is the previous staging.
- enable deasserted in BLANK or SHOW:
  - Next edge goes to IDLE, outputs dark, digit_idx 0, div_cnt 0.
  - No frame_done pulse.
  - Pending is committed to shadow on entering IDLE.
- Invalid nibbles 10-15: the decoder output is passed through (all segments off). The anode is still driven low for the slot.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, digit k > 0 is forced to seg_n 7'h7F and dp_n 1 when its nibble and all higher nibbles are 0 and none of their dp bits are set.
  - Digit 0 is never suppressed.
  - The anode is still driven low; slot timing is unchanged.
- Undefined: every digit is decoded as-is, including zeros.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset: rst_n=0 for 3 cycles with enable=1 and load=1 -> an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0, all held; after release with enable=1, first 2 cycles dark.
- Normal scan: load 16'h1234 in IDLE, dp_in=0, then enable=1 -> per 8-cycle slot, 2 cycles dark, then 6 cycles of:
  - an_n=1110, seg_n=0011001 ('4')
  - then an_n=1101, seg_n=0110000
  - then an_n=1011, seg_n=0100100
  - then an_n=0111, seg_n=1111001
  - frame_done pulses once every 32 cycles.
- Tear-free load: with 16'h1234 displayed, load 16'h5678 during digit 1 SHOW -> digits 2 and 3 still show '2' and '1'; next frame digit 0 shows 0000000 ('8') and digit 3 shows 0010010 ('5').
- Load races: load at the exact boundary edge -> old value shown for one more full frame. Two loads (16'h1111 then 16'h2222) in one frame -> next frame shows 2222.
- Invalid and disable: nibble 4'hA on digit 2 -> seg_n=7'h7F while an_n=1011. Drop enable mid-SHOW of digit 1 -> next cycle an_n=4'hF and no frame_done; re-enable -> 2 dark cycles, then digit 0.
- Macro: with LEADING_ZERO_BLANK_EN, value 16'h0070, dp_in=0 -> digits 3 and 2 show 7'h7F, digit 1 shows 1111000, digit 0 shows 1000000. Without the macro, digits 3 and 2 show 1000000.
